pal_ram_dp: RTL and testbench
=============================

# pal_ram_dp

Dual-port palette memory for the PPU: a write/read port for the CPU-facing register path ($2007 palette accesses) and a read-only render port for the pixel pipeline. Implements NES backdrop mirroring in hardware, registered 1-cycle reads, write-first render forwarding, greyscale masking, and a sequenced clear after reset or on request. Replaces the single-port palette array between the PPU register block and the pixel mux.

## Interface
Parameters:
- DATA_W, 8: entry width in bits.
- ADDR_W, 5: address width; depth = 2**ADDR_W.
- MIRROR_EN, 1: enable backdrop mirroring (requires ADDR_W >= 5).
- INIT_VAL, 0: value written to every entry by the clear sweep.
- GREY_MASK, 8'h30: AND mask applied to render data when greyscale=1.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- clk_en  in  1  PPU clock enable (master/4); all state advances only when high.
- clr  in  1  start/restart the clear sweep.
- busy  out  1  clear sweep in progress.
- cpu_addr  in  ADDR_W  CPU-port address.
- cpu_we  in  1  CPU write strobe.
- cpu_re  in  1  CPU read strobe.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_rdata  out  DATA_W  CPU read data.
- cpu_rvalid  out  1  cpu_rdata valid for this clk_en cycle.
- rd_addr  in  ADDR_W  render-port address.
- rd_en  in  1  render read strobe.
- greyscale  in  1  PPUMASK greyscale bit.
- rd_data  out  DATA_W  render read data.
- rd_valid  out  1  rd_data valid for this clk_en cycle.

## Operation
- FSM states: CLEAR, READY. rst -> CLEAR with sweep pointer 0. clr (any state) -> CLEAR, pointer 0.
- CLEAR: each clk_en cycle write INIT_VAL to mem[ptr], ptr++; after writing entry 2**ADDR_W-1 -> READY. busy=1 throughout CLEAR.
- During CLEAR all CPU and render requests are dropped: no write, rvalid/rd_valid stay 0.
- Address mapping (both ports, when MIRROR_EN): if addr[4]=1 and addr[1:0]=00, clear addr[4] (0x10/14/18/1C -> 0x00/04/08/0C). Higher address bits pass unchanged.
- CPU port: cpu_we has priority; if cpu_we and cpu_re together, write only, cpu_rvalid=0. Write updates mem[map(cpu_addr)].
- CPU read: cpu_rdata = mem[map(cpu_addr)] registered; cpu_rvalid pulses for one clk_en cycle.
- Render read: rd_data = mem[map(rd_addr)] registered, then AND GREY_MASK if greyscale sampled with the request; rd_valid pulses one clk_en cycle.
- Collision: CPU write and render read to the same mapped address in the same cycle -> render returns cpu_wdata (write-first). Mirrored aliases (e.g. write 0x10, read 0x00) count as same address.
- When clk_en=0: no memory update, no pointer advance, outputs hold.

## Timing
- Reset values: busy=1, cpu_rdata=0, cpu_rvalid=0, rd_data=0, rd_valid=0, ptr=0.
- rst is sampled on every clk edge regardless of clk_en; wins over clr and all requests.
- Read latency: 1 clk_en cycle (request on enabled edge N, data/valid after edge N, valid until the next enabled edge).
- Clear sweep length: exactly 2**ADDR_W clk_en cycles; busy falls on the edge that writes the last entry; a request in the following clk_en cycle is serviced.
- clr mid-sweep restarts at pointer 0; total sweep re-extends.
- Valid strobes deassert on the next clk_en edge with no request.

## Structure
- Package pal_pkg: state enum (CLEAR, READY), function map_addr (mirroring), default GREY_MASK constant.
- One sub-module: pal_clear_seq (FSM + sweep pointer, outputs busy, clr_we, clr_addr). Memory array, mirroring and read registers in top.

## Test plan
- Reset then 32 clk_en cycles -> busy high 32 cycles, then 0; read 0x00..0x1F all return INIT_VAL.
- Write 0x2A to 0x10, CPU read 0x00 -> cpu_rdata=0x2A one cycle later; read 0x11 unaffected (INIT_VAL).
- Same cycle CPU write 0x15 to 0x04 and render read 0x14 -> rd_data=0x15.
- Entry 0x05=0x3F, render read with greyscale=1 -> rd_data=0x30; greyscale=0 -> 0x3F.
- cpu_we+cpu_re together at 0x03 -> cpu_rvalid=0, mem updated; clk_en held low 3 cycles -> no outputs change.
- clr asserted at sweep pointer 10 -> busy stays high 32 further clk_en cycles; requests during sweep give no rvalid.

Source files
------------

// File: rtl/pal_pkg.sv
// rtl/pal_pkg.sv - shared types, constants and address mirroring for the palette RAM
package pal_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } pal_state_t;

   localparam logic [7:0] GREY_MASK_DEF = 8'h30;

   // Sprite-palette backdrop slots (0x10/14/18/1C) alias the background ones.
   function automatic logic [4:0] map_addr(input logic [4:0] addr);
      logic [4:0] m;
      m = addr;
      if (addr[4] && (addr[1:0] == 2'b00)) begin
         m[4] = 1'b0;
      end
      return m;
   endfunction

endpackage

// File: rtl/pal_clear_seq.sv
// rtl/pal_clear_seq.sv - clear sweep sequencer: walks every entry after reset or clr
module pal_clear_seq
   import pal_pkg::*;
#(
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clk_en,
   input  logic              clr,
   output logic              busy,
   output logic              clr_we,
   output logic [ADDR_W-1:0] clr_addr
);

   pal_state_t        state;
   pal_state_t        state_nxt;
   logic [ADDR_W-1:0] ptr;
   logic [ADDR_W-1:0] ptr_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= CLEAR;
         ptr   <= '0;
      end else if (clk_en) begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
      end
   end

   // A clr edge only rewinds the pointer; the sweep writes start on the next enabled edge.
   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      busy      = (state == CLEAR);
      clr_we    = (state == CLEAR) && !clr;
      clr_addr  = ptr;
      if (clr) begin
         state_nxt = CLEAR;
         ptr_nxt   = '0;
      end else if (state == CLEAR) begin
         ptr_nxt = ptr + ADDR_W'(1);
         if (ptr == '1) begin
            state_nxt = READY;
         end
      end
   end

endmodule

// File: rtl/pal_ram_dp.sv
// rtl/pal_ram_dp.sv - dual-port PPU palette RAM with mirroring, write-first render path and greyscale
module pal_ram_dp
   import pal_pkg::*;
#(
   parameter int                DATA_W    = 8,
   parameter int                ADDR_W    = 5,
   parameter bit                MIRROR_EN = 1'b1,
   parameter logic [DATA_W-1:0] INIT_VAL  = '0,
   parameter logic [DATA_W-1:0] GREY_MASK = DATA_W'(GREY_MASK_DEF)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clk_en,
   input  logic              clr,
   output logic              busy,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic              cpu_we,
   input  logic              cpu_re,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_rvalid,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic              rd_en,
   input  logic              greyscale,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   logic              clr_we;
   logic [ADDR_W-1:0] clr_addr;
   logic [ADDR_W-1:0] cpu_map;
   logic [ADDR_W-1:0] rd_map;
   logic              serve;
   logic              cpu_wr;
   logic              cpu_rd;
   logic              rnd_rd;
   logic              collide;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] rd_word;
   logic [DATA_W-1:0] rd_mask;

   pal_clear_seq #(
      .ADDR_W (ADDR_W)
   ) u_clear_seq (
      .clk      (clk),
      .rst      (rst),
      .clk_en   (clk_en),
      .clr      (clr),
      .busy     (busy),
      .clr_we   (clr_we),
      .clr_addr (clr_addr)
   );

   generate
      if (MIRROR_EN && (ADDR_W >= 5)) begin : g_mirror
         always_comb begin
            cpu_map      = cpu_addr;
            cpu_map[4:0] = map_addr(cpu_addr[4:0]);
            rd_map       = rd_addr;
            rd_map[4:0]  = map_addr(rd_addr[4:0]);
         end
      end else begin : g_flat
         assign cpu_map = cpu_addr;
         assign rd_map  = rd_addr;
      end
   endgenerate

   // Requests are dropped while sweeping and on the edge that (re)starts a sweep.
   assign serve   = !busy && !clr;
   assign cpu_wr  = serve && cpu_we;
   assign cpu_rd  = serve && cpu_re && !cpu_we;
   assign rnd_rd  = serve && rd_en;
   assign collide = cpu_wr && (cpu_map == rd_map);

   assign mem_we    = clr_we || cpu_wr;
   assign mem_waddr = clr_we ? clr_addr : cpu_map;
   assign mem_wdata = clr_we ? INIT_VAL : cpu_wdata;

   assign rd_word = collide ? cpu_wdata : mem[rd_map];
   assign rd_mask = greyscale ? GREY_MASK : '1;

   always_ff @(posedge clk) begin
      if (!rst && clk_en && mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cpu_rdata  <= '0;
         cpu_rvalid <= 1'b0;
         rd_data    <= '0;
         rd_valid   <= 1'b0;
      end else if (clk_en) begin
         cpu_rvalid <= cpu_rd;
         rd_valid   <= rnd_rd;
         if (cpu_rd) begin
            cpu_rdata <= mem[cpu_map];
         end
         if (rnd_rd) begin
            rd_data <= rd_word & rd_mask;
         end
      end
   end

endmodule

// File: tb/tb_pal_ram_dp.sv
// tb/tb_pal_ram_dp.sv - self-checking bench for pal_ram_dp
module tb_pal_ram_dp;

   localparam logic [7:0] INIT = 8'h0F;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       clk_en = 1'b1;
   logic       clr = 1'b0;
   logic       busy;
   logic [4:0] cpu_addr = '0;
   logic       cpu_we = 1'b0;
   logic       cpu_re = 1'b0;
   logic [7:0] cpu_wdata = '0;
   logic [7:0] cpu_rdata;
   logic       cpu_rvalid;
   logic [4:0] rd_addr = '0;
   logic       rd_en = 1'b0;
   logic       greyscale = 1'b0;
   logic [7:0] rd_data;
   logic       rd_valid;

   int n_checks = 0;
   int n_fail = 0;

   logic [7:0] cpu_q[$];
   logic [7:0] rd_q[$];

   typedef struct {
      logic       we;
      logic       re;
      logic [4:0] addr;
      logic [7:0] wd;
      logic       ren;
      logic [4:0] raddr;
      logic       grey;
      logic       cv;
      logic [7:0] cd;
      logic       rv;
      logic [7:0] rdv;
   } vec_t;

   vec_t vt[15];

   pal_ram_dp #(
      .DATA_W    (8),
      .ADDR_W    (5),
      .MIRROR_EN (1'b1),
      .INIT_VAL  (INIT),
      .GREY_MASK (8'h30)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .clk_en     (clk_en),
      .clr        (clr),
      .busy       (busy),
      .cpu_addr   (cpu_addr),
      .cpu_we     (cpu_we),
      .cpu_re     (cpu_re),
      .cpu_wdata  (cpu_wdata),
      .cpu_rdata  (cpu_rdata),
      .cpu_rvalid (cpu_rvalid),
      .rd_addr    (rd_addr),
      .rd_en      (rd_en),
      .greyscale  (greyscale),
      .rd_data    (rd_data),
      .rd_valid   (rd_valid)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic idle();
      cpu_we = 1'b0;
      cpu_re = 1'b0;
      rd_en = 1'b0;
      greyscale = 1'b0;
   endtask

   task automatic step(input logic exp_cv, input logic exp_rv);
      @(posedge clk);
      #1;
      chk("cpu_rvalid", cpu_rvalid, exp_cv);
      chk("rd_valid", rd_valid, exp_rv);
      if (cpu_rvalid) begin
         if (cpu_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL cpu_sb: unexpected cpu data %0h, none expected", cpu_rdata);
         end else begin
            chk("cpu_rdata", cpu_rdata, cpu_q.pop_front());
         end
      end
      if (rd_valid) begin
         if (rd_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL rd_sb: unexpected render data %0h, none expected", rd_data);
         end else begin
            chk("rd_data", rd_data, rd_q.pop_front());
         end
      end
   endtask

   task automatic req(input vec_t v);
      cpu_we = v.we;
      cpu_re = v.re;
      cpu_addr = v.addr;
      cpu_wdata = v.wd;
      rd_en = v.ren;
      rd_addr = v.raddr;
      greyscale = v.grey;
      if (v.cv) cpu_q.push_back(v.cd);
      if (v.rv) rd_q.push_back(v.rdv);
      step(v.cv, v.rv);
      idle();
   endtask

   // Counts enabled edges until busy drops, hammering both ports meanwhile.
   task automatic sweep_count(output int n);
      n = 0;
      for (int i = 0; i < 100; i++) begin
         cpu_we = i[0];
         cpu_re = !i[0];
         cpu_addr = 5'h00;
         cpu_wdata = 8'hEE;
         rd_en = 1'b1;
         rd_addr = 5'h00;
         step(1'b0, 1'b0);
         n++;
         if (!busy) break;
      end
      idle();
   endtask

   initial begin
      int n;
      vec_t v;

      vt[0]  = '{1'b1, 1'b0, 5'h10, 8'h2A, 1'b0, 5'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00};
      vt[1]  = '{1'b0, 1'b1, 5'h00, 8'h00, 1'b0, 5'h00, 1'b0, 1'b1, 8'h2A, 1'b0, 8'h00};
      vt[2]  = '{1'b0, 1'b1, 5'h11, 8'h00, 1'b0, 5'h00, 1'b0, 1'b1, INIT,  1'b0, 8'h00};
      vt[3]  = '{1'b1, 1'b0, 5'h04, 8'h15, 1'b1, 5'h14, 1'b0, 1'b0, 8'h00, 1'b1, 8'h15};
      vt[4]  = '{1'b0, 1'b1, 5'h04, 8'h00, 1'b1, 5'h14, 1'b0, 1'b1, 8'h15, 1'b1, 8'h15};
      vt[5]  = '{1'b1, 1'b0, 5'h05, 8'h3F, 1'b0, 5'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00};
      vt[6]  = '{1'b0, 1'b0, 5'h00, 8'h00, 1'b1, 5'h05, 1'b1, 1'b0, 8'h00, 1'b1, 8'h30};
      vt[7]  = '{1'b0, 1'b1, 5'h15, 8'h00, 1'b1, 5'h05, 1'b0, 1'b1, INIT,  1'b1, 8'h3F};
      vt[8]  = '{1'b1, 1'b1, 5'h03, 8'h77, 1'b0, 5'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00};
      vt[9]  = '{1'b0, 1'b1, 5'h03, 8'h00, 1'b0, 5'h00, 1'b0, 1'b1, 8'h77, 1'b0, 8'h00};
      vt[10] = '{1'b1, 1'b0, 5'h1C, 8'h0C, 1'b1, 5'h0C, 1'b0, 1'b0, 8'h00, 1'b1, 8'h0C};
      vt[11] = '{1'b0, 1'b1, 5'h1C, 8'h00, 1'b1, 5'h1F, 1'b0, 1'b1, 8'h0C, 1'b1, INIT};
      vt[12] = '{1'b1, 1'b0, 5'h08, 8'hFF, 1'b1, 5'h18, 1'b1, 1'b0, 8'h00, 1'b1, 8'h30};
      vt[13] = '{1'b0, 1'b1, 5'h18, 8'h00, 1'b1, 5'h10, 1'b0, 1'b1, 8'hFF, 1'b1, 8'h2A};
      vt[14] = '{1'b0, 1'b0, 5'h00, 8'h00, 1'b0, 5'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00};

      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      chk("rst_busy", busy, 1'b1);
      chk("rst_cpu_rdata", cpu_rdata, 8'h00);
      chk("rst_cpu_rvalid", cpu_rvalid, 1'b0);
      chk("rst_rd_data", rd_data, 8'h00);
      chk("rst_rd_valid", rd_valid, 1'b0);
      rst = 1'b0;

      sweep_count(n);
      chk("rst_sweep_len", n, 32);

      for (int i = 0; i < 32; i++) begin
         v = '{1'b0, 1'b1, 5'(i), 8'h00, 1'b1, 5'(31 - i), 1'b0, 1'b1, INIT, 1'b1, INIT};
         req(v);
      end

      for (int i = 0; i < 15; i++) begin
         req(vt[i]);
      end

      v = '{1'b0, 1'b1, 5'h00, 8'h00, 1'b0, 5'h00, 1'b0, 1'b1, 8'h2A, 1'b0, 8'h00};
      req(v);
      clk_en = 1'b0;
      cpu_we = 1'b1;
      cpu_addr = 5'h00;
      cpu_wdata = 8'h55;
      rd_en = 1'b1;
      rd_addr = 5'h05;
      clr = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("hold_cpu_rvalid", cpu_rvalid, 1'b1);
         chk("hold_cpu_rdata", cpu_rdata, 8'h2A);
         chk("hold_rd_valid", rd_valid, 1'b0);
         chk("hold_rd_data", rd_data, 8'h2A);
         chk("hold_busy", busy, 1'b0);
      end
      clr = 1'b0;
      idle();
      clk_en = 1'b1;
      v = '{1'b0, 1'b1, 5'h00, 8'h00, 1'b1, 5'h05, 1'b0, 1'b1, 8'h2A, 1'b1, 8'h3F};
      req(v);

      clr = 1'b1;
      step(1'b0, 1'b0);
      clr = 1'b0;
      chk("clr_busy", busy, 1'b1);
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 1'b0);
      end
      clr = 1'b1;
      step(1'b0, 1'b0);
      clr = 1'b0;
      sweep_count(n);
      chk("clr_sweep_len", n, 32);

      v = '{1'b0, 1'b1, 5'h00, 8'h00, 1'b1, 5'h18, 1'b0, 1'b1, INIT, 1'b1, INIT};
      req(v);
      v = '{1'b0, 1'b1, 5'h03, 8'h00, 1'b1, 5'h05, 1'b1, 1'b1, INIT, 1'b1, 8'h00};
      req(v);
      step(1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
